mode_controller: RTL
====================

# mode_controller

Central sequencer for the digital-clock top level: decides which service (clock display, time set, alarm set, stopwatch, alarm ring / mini game) currently owns the five push buttons and the seven-segment display. It converts raw push levels into single-cycle pulses and routes them to the owning service only. It also drives the edit-enable and display-select lines consumed by the time, alarm, stopwatch and mini-game blocks inside `Main`.

## Interface
- `PUSH_W`, 5: number of push buttons.
- `RING_TIMEOUT`, 60: `tick_1hz` pulses after which an unanswered alarm stops ringing (only with the macro).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick_1hz` in 1: one-cycle pulse per second.
- `push` in PUSH_W: raw button levels, synchronous to `clk`.
- `spdt_mode` in 4: [3] time set, [2] alarm set, [1] stopwatch, [0] alarm enable (board spdt[14:11]).
- `alarm_match` in 1: one-cycle pulse from the alarm block when current time equals alarm time.
- `game_clear` in 1: one-cycle pulse from the mini game when solved.
- `push_time`, `push_alarm`, `push_sw`, `push_game` out PUSH_W each: routed one-cycle push pulses.
- `time_edit_en`, `alarm_edit_en` out 1: high while in TSET / ASET; `time_edit_en` freezes time counting.
- `ringing` out 1: high in RING; drives the alarm LEDs.
- `disp_sel` out 3: 0 clock, 1 time set, 2 alarm set, 3 stopwatch, 4 game.

## Operation
- States: CLOCK, TSET, ASET, SWATCH, RING. `disp_sel` equals the state code (RING=4).
- Switch-derived target: `spdt_mode[3]` gives TSET; else `[2]` gives ASET; else `[1]` gives SWATCH; else CLOCK. Fixed priority TSET > ASET > SWATCH.
- In CLOCK, TSET, ASET and SWATCH, the next state is the switch-derived target, unless RING entry applies.
- RING entry: `alarm_match` && `spdt_mode[0]` && state is CLOCK or SWATCH. Wins over any simultaneous switch change. `alarm_match` in TSET or ASET is dropped, not queued.
- RING exit goes to the switch-derived target on either of:
  - `game_clear`;
  - `spdt_mode[0]` low.
- Switch changes are ignored while in RING.
- Push edges:
  - `push_q` holds last cycle's `push`.
  - `edge = push & ~push_q`.
  - The edge is routed, registered, to the owner: CLOCK routes to none; TSET to `push_time`; ASET to `push_alarm`; SWATCH to `push_sw`; RING to `push_game`.
  - Non-owners get 0.
- Edges are dropped in any cycle where the state changes. A button held across a mode change produces no pulse in the new mode.
- Stopwatch counting is not stopped by leaving SWATCH. The controller only withholds buttons.

## Timing
- Reset values:
  - state CLOCK, `disp_sel` 0;
  - all push outputs 0;
  - `time_edit_en`, `alarm_edit_en`, `ringing` 0;
  - ring counter 0;
  - `push_q` all ones, so buttons held through reset do not pulse on release of `rst`.
- Switch change sampled at edge n: state, `disp_sel` and edit enables change at edge n+1.
- Push rising at edge n: the routed pulse is high for exactly the cycle after edge n+1 (1-cycle latency). It is one cycle wide regardless of hold length.
- `alarm_match` at edge n: `ringing` is high after edge n+1. `game_clear` at edge m: `ringing` is low after edge m+1.
- `rst` mid-RING or mid-press returns everything to reset values at the next edge; no pulse is emitted.

## Configuration
- `MODE_RING_TIMEOUT_EN` defined:
  - A counter increments on `tick_1hz` while in RING and clears on RING entry.
  - When it reaches `RING_TIMEOUT`, the next state is the switch-derived target.
  - The counter width is clog2(RING_TIMEOUT+1).
- Macro undefined: no counter exists. RING is left only by `game_clear` or clearing the alarm enable.

## Structure
- Package `mode_ctrl_pkg`:
  - state encoding constants (CLOCK=0, TSET=1, ASET=2, SWATCH=3, RING=4);
  - `disp_sel` constants;
  - the `spdt_mode` bit index constants.
- Sub-module `push_edge` (parameter `PUSH_W`): `push_q` register with set-to-ones reset and the rising-edge vector. It is instantiated once.
- Remaining logic stays in `mode_controller`: next-state logic, output routing registers and the optional timeout counter.

## Test plan
- Reset: hold `rst` 3 cycles with `push`=5'b00001 held → after release `disp_sel`=0, all push outputs 0, no `push_time` pulse when `spdt_mode`=4'b1000 later.
- Time set: `spdt_mode`=4'b1000, 10 presses of `push[0]` → exactly 10 one-cycle pulses on `push_time[0]`, none elsewhere, `time_edit_en`=1, `disp_sel`=1.
- Priority: `spdt_mode`=4'b1110 → TSET (`disp_sel`=1); clear bit 3 → ASET (2); clear bit 2 → SWATCH (3); a `push[4]` press in SWATCH → one `push_sw[4]` pulse.
- Ring and clear: `spdt_mode`=4'b0001, pulse `alarm_match` → `ringing`=1, `disp_sel`=4; then set `spdt_mode`=4'b1001 → stays RING; pulse `game_clear` → `ringing`=0 and the next state is TSET.
- Suppression: `alarm_match` pulsed in ASET → `ringing` stays 0. `alarm_match` with `spdt_mode[0]`=0 → `ringing` stays 0.
- Timeout (macro defined, `RING_TIMEOUT`=3): enter RING, apply 3 `tick_1hz` pulses → `ringing` drops one cycle after the third. Without the macro it stays high after 100 ticks.

Source files
------------

// File: rtl/mode_ctrl_pkg.sv
// Shared encodings for the digital-clock mode controller: state codes,
// display-select codes and the meaning of each spdt_mode bit.
package mode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLOCK  = 3'd0,
        ST_TSET   = 3'd1,
        ST_ASET   = 3'd2,
        ST_SWATCH = 3'd3,
        ST_RING   = 3'd4
    } mode_state_t;

    // disp_sel codes deliberately match the state codes
    localparam logic [2:0] DISP_CLOCK  = 3'd0;
    localparam logic [2:0] DISP_TSET   = 3'd1;
    localparam logic [2:0] DISP_ASET   = 3'd2;
    localparam logic [2:0] DISP_SWATCH = 3'd3;
    localparam logic [2:0] DISP_GAME   = 3'd4;

    // spdt_mode bit positions (board spdt[14:11])
    localparam int SW_TSET     = 3;
    localparam int SW_ASET     = 2;
    localparam int SW_SWATCH   = 1;
    localparam int SW_ALARM_EN = 0;

    // Mode requested by the slide switches, fixed priority TSET > ASET > SWATCH
    function automatic mode_state_t switch_target(input logic [3:0] sw);
        if (sw[SW_TSET])        return ST_TSET;
        else if (sw[SW_ASET])   return ST_ASET;
        else if (sw[SW_SWATCH]) return ST_SWATCH;
        else                    return ST_CLOCK;
    endfunction

endpackage

// File: rtl/mode_controller_push_edge.sv
// Rising-edge detector for the push buttons. The history register resets to
// all ones so a button held through reset does not pulse when reset lifts.
module push_edge #(
    parameter int PUSH_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PUSH_W-1:0] push,
    output logic [PUSH_W-1:0] rise
);

    logic [PUSH_W-1:0] push_q;

    // remember last cycle's button levels
    always_ff @(posedge clk) begin
        if (rst) push_q <= '1;
        else     push_q <= push;
    end

    assign rise = push & ~push_q;

endmodule

// File: rtl/mode_controller.sv
// Digital-clock mode sequencer: picks which service owns the buttons and
// display, and routes single-cycle button pulses to that owner only.
// Optional feature: define MODE_RING_TIMEOUT_EN to stop an unanswered alarm
// after RING_TIMEOUT tick_1hz pulses.
module mode_controller
    import mode_ctrl_pkg::*;
#(
    parameter int PUSH_W       = 5,
    parameter int RING_TIMEOUT = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [PUSH_W-1:0] push,
    input  logic [3:0]        spdt_mode,
    input  logic              alarm_match,
    input  logic              game_clear,
    output logic [PUSH_W-1:0] push_time,
    output logic [PUSH_W-1:0] push_alarm,
    output logic [PUSH_W-1:0] push_sw,
    output logic [PUSH_W-1:0] push_game,
    output logic              time_edit_en,
    output logic              alarm_edit_en,
    output logic              ringing,
    output logic [2:0]        disp_sel
);

    mode_state_t       state, state_nxt, target;
    logic [PUSH_W-1:0] rise;
    logic              timeout;
    logic              ring_entry;

    push_edge #(.PUSH_W(PUSH_W)) u_push_edge (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .rise (rise)
    );

    assign ring_entry = (state_nxt == ST_RING) && (state != ST_RING);

`ifdef MODE_RING_TIMEOUT_EN
    localparam int CNT_W = $clog2(RING_TIMEOUT + 1);
    logic [CNT_W-1:0] ring_cnt;

    // count seconds spent ringing; saturates at the timeout value
    always_ff @(posedge clk) begin
        if (rst)
            ring_cnt <= '0;
        else if (ring_entry)
            ring_cnt <= '0;
        else if (state == ST_RING && tick_1hz && ring_cnt != CNT_W'(RING_TIMEOUT))
            ring_cnt <= ring_cnt + 1'b1;
    end

    assign timeout = (state == ST_RING) && (ring_cnt == CNT_W'(RING_TIMEOUT));
`else
    logic unused_cfg;
    assign unused_cfg = tick_1hz ^ RING_TIMEOUT[0];
    assign timeout    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLOCK;
        else     state <= state_nxt;
    end

    // next state: switches rule except while ringing; alarm preempts CLOCK/SWATCH
    always_comb begin
        target    = switch_target(spdt_mode);
        state_nxt = target;
        case (state)
            ST_RING: begin
                if (game_clear || !spdt_mode[SW_ALARM_EN] || timeout)
                    state_nxt = target;
                else
                    state_nxt = ST_RING;
            end
            ST_CLOCK, ST_SWATCH: begin
                if (alarm_match && spdt_mode[SW_ALARM_EN])
                    state_nxt = ST_RING;
            end
            default: state_nxt = target;
        endcase
    end

    // route button edges to the current owner; drop them on a mode change
    always_ff @(posedge clk) begin
        if (rst) begin
            push_time  <= '0;
            push_alarm <= '0;
            push_sw    <= '0;
            push_game  <= '0;
        end else begin
            push_time  <= '0;
            push_alarm <= '0;
            push_sw    <= '0;
            push_game  <= '0;
            if (state_nxt == state) begin
                case (state)
                    ST_TSET:   push_time  <= rise;
                    ST_ASET:   push_alarm <= rise;
                    ST_SWATCH: push_sw    <= rise;
                    ST_RING:   push_game  <= rise;
                    default:   ;
                endcase
            end
        end
    end

    assign time_edit_en  = (state == ST_TSET);
    assign alarm_edit_en = (state == ST_ASET);
    assign ringing       = (state == ST_RING);
    assign disp_sel      = state;

endmodule
